// File: rtl/add3_accumulator.sv
// Saturating batch accumulator for the 3-bit adder's {cout,sum} results.
// Accepts COUNT beats, presents the total with a sticky overflow flag, then restarts.
module add3_accumulator #(
  parameter int ACC_W = 8,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       sum,
  input  logic             cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf
);

  localparam int CNT_W = $clog2(COUNT + 1);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic             w_release;
  logic [ACC_W:0]   w_sum;

  // One extra bit on the sum makes the saturation test a single carry bit.
  assign w_sum     = {1'b0, r_acc} + {{(ACC_W - 3){1'b0}}, cout, sum};
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_cnt == CNT_W'(COUNT - 1));
  assign w_release = (r_state == DONE) && out_ready;

  assign acc_out = r_acc;
  assign ovf     = r_ovf;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      ACCUM: begin
        in_ready = !clr;
        if (w_accept && w_last) w_next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = ACCUM;
      end
      default: w_next_state = ACCUM;
    endcase
    if (clr) w_next_state = ACCUM;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (clr || w_release) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      if (w_sum[ACC_W]) begin
        r_acc <= '1;
        r_ovf <= 1'b1;
      end else begin
        r_acc <= w_sum[ACC_W-1:0];
      end
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_add3_accumulator.sv
// Directed bench for add3_accumulator: a vector table on an ACC_W=8/COUNT=4
// instance plus hand sequences for saturation (ACC_W=5/COUNT=3) and reset in DONE.
module tb_add3_accumulator;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] beat;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] acc_out;
  logic       ovf;

  logic       s_clr;
  logic       s_in_valid;
  logic       s_in_ready;
  logic [3:0] s_beat;
  logic       s_out_valid;
  logic       s_out_ready;
  logic [4:0] s_acc_out;
  logic       s_ovf;

  int n_checks = 0;
  int n_errors = 0;

  add3_accumulator #(.ACC_W(8), .COUNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .sum(beat[2:0]), .cout(beat[3]),
    .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .ovf(ovf)
  );

  add3_accumulator #(.ACC_W(5), .COUNT(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .clr(s_clr),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .sum(s_beat[2:0]), .cout(s_beat[3]),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .acc_out(s_acc_out), .ovf(s_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       ordy;
    logic       c;
    logic       e_rdy;
    logic       e_vld;
    logic [7:0] e_acc;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [3:0] d, logic ordy, logic c,
                              logic e_rdy, logic e_vld, logic [7:0] e_acc, logic e_ovf);
    vec_t t;
    t.v = v; t.d = d; t.ordy = ordy; t.c = c;
    t.e_rdy = e_rdy; t.e_vld = e_vld; t.e_acc = e_acc; t.e_ovf = e_ovf;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; beat = '0; out_ready = 1'b0;
    s_clr = 1'b0; s_in_valid = 1'b0; s_beat = '0; s_out_ready = 1'b0;

    // Scenario 2: basic batch 3+5+8+1 = 17, drained immediately.
    vecs.push_back(mk(1, 4'd3, 1, 0, 1, 0, 8'd3,  0));
    vecs.push_back(mk(1, 4'd5, 1, 0, 1, 0, 8'd8,  0));
    vecs.push_back(mk(1, 4'd8, 1, 0, 1, 0, 8'd16, 0));
    vecs.push_back(mk(1, 4'd1, 1, 0, 1, 1, 8'd17, 0));
    vecs.push_back(mk(0, 4'd0, 1, 0, 0, 0, 8'd0,  0));
    // Scenario 3: same batch, then 5 cycles of backpressure with 4'b1111 pending.
    vecs.push_back(mk(1, 4'd3, 0, 0, 1, 0, 8'd3,  0));
    vecs.push_back(mk(1, 4'd5, 0, 0, 1, 0, 8'd8,  0));
    vecs.push_back(mk(1, 4'd8, 0, 0, 1, 0, 8'd16, 0));
    vecs.push_back(mk(1, 4'd1, 0, 0, 1, 1, 8'd17, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 4'd15, 0, 0, 0, 1, 8'd17, 0));
    vecs.push_back(mk(1, 4'd15, 1, 0, 0, 0, 8'd0,  0));
    vecs.push_back(mk(1, 4'd15, 0, 0, 1, 0, 8'd15, 0));
    vecs.push_back(mk(0, 4'd0,  0, 1, 0, 0, 8'd0,  0));
    // Scenario 5: two 7s, a refused beat during clr, then four 1s.
    vecs.push_back(mk(1, 4'd7, 0, 0, 1, 0, 8'd7,  0));
    vecs.push_back(mk(1, 4'd7, 0, 0, 1, 0, 8'd14, 0));
    vecs.push_back(mk(1, 4'd7, 0, 1, 0, 0, 8'd0,  0));
    vecs.push_back(mk(1, 4'd1, 0, 0, 1, 0, 8'd1,  0));
    vecs.push_back(mk(1, 4'd1, 0, 0, 1, 0, 8'd2,  0));
    vecs.push_back(mk(1, 4'd1, 0, 0, 1, 0, 8'd3,  0));
    vecs.push_back(mk(1, 4'd1, 0, 0, 1, 1, 8'd4,  0));
    vecs.push_back(mk(0, 4'd0, 1, 0, 0, 0, 8'd0,  0));

    // Scenario 1: reset values.
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_acc_out", acc_out, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_s_out_valid", s_out_valid, 0);
    check("rst_s_acc_out", s_acc_out, 0);
    clr = 1'b1;
    #1;
    check("rst_in_ready_clr", in_ready, 0);
    clr = 1'b0;

    foreach (vecs[i]) begin
      in_valid = vecs[i].v; beat = vecs[i].d; out_ready = vecs[i].ordy; clr = vecs[i].c;
      #1;
      check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_rdy);
      tick();
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_vld);
      check($sformatf("vec%0d_acc_out", i), acc_out, vecs[i].e_acc);
      check($sformatf("vec%0d_ovf", i), ovf, vecs[i].e_ovf);
    end
    in_valid = 1'b0; clr = 1'b0; out_ready = 1'b0;

    // Scenario 4: 15+15+15 saturates a 5-bit accumulator at 31.
    s_in_valid = 1'b1; s_beat = 4'd15;
    tick();
    check("sat_beat1_acc", s_acc_out, 15);
    tick();
    check("sat_beat2_acc", s_acc_out, 30);
    check("sat_beat2_ovf", s_ovf, 0);
    tick();
    check("sat_beat3_acc", s_acc_out, 31);
    check("sat_beat3_ovf", s_ovf, 1);
    check("sat_out_valid", s_out_valid, 1);
    check("sat_in_ready", s_in_ready, 0);
    s_in_valid = 1'b0; s_out_ready = 1'b1;
    tick();
    check("sat_drain_ovf", s_ovf, 0);
    check("sat_drain_acc", s_acc_out, 0);
    check("sat_drain_out_valid", s_out_valid, 0);
    s_out_ready = 1'b0;

    // Scenario 6: reach DONE with 2+2+2+2, then reset while held.
    in_valid = 1'b1; beat = 4'd2;
    repeat (4) tick();
    check("done_out_valid", out_valid, 1);
    check("done_acc_out", acc_out, 8);
    in_valid = 1'b0; rst_n = 1'b0;
    tick();
    check("rstdone_out_valid", out_valid, 0);
    check("rstdone_acc_out", acc_out, 0);
    check("rstdone_ovf", ovf, 0);
    rst_n = 1'b1;
    #1;
    check("rstdone_in_ready", in_ready, 1);
    in_valid = 1'b1; beat = 4'd9;
    tick();
    check("rstdone_restart_acc", acc_out, 9);
    in_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
